// File: rtl/usb_pkt_buffer_if.sv
// rtl/usb_pkt_buffer_if.sv - capture ingress and HSPI egress signal bundle for usb_pkt_buffer
interface usb_pkt_buffer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_eop;
    logic        in_err;
    logic        req;
    logic [11:0] xfer_len;
    logic [25:0] usdf;
    logic        ack;
    logic [7:0]  payload_data;
    logic        pkt_pending;
    logic [15:0] drop_cnt;

    modport slave (
        input  in_valid, in_data, in_eop, in_err, ack,
        output req, xfer_len, usdf, payload_data, pkt_pending, drop_cnt
    );

    modport master (
        output in_valid, in_data, in_eop, in_err, ack,
        input  req, xfer_len, usdf, payload_data, pkt_pending, drop_cnt
    );
endinterface

// File: rtl/usb_pkt_buffer.sv
// rtl/usb_pkt_buffer.sv - whole-packet buffer between the USB sniffer decoder and the HSPI transmit master
// Bytes land in a data FIFO; a descriptor is pushed only when a packet commits, so egress never sees partial packets.
module usb_pkt_buffer #(
    parameter int DATA_AW = 11,
    parameter int DESC_AW = 4,
    parameter int MAX_LEN = 1024
) (
    input  logic            clk,
    input  logic            rst,
    usb_pkt_buffer_if.slave bus
);
    localparam int DEPTH  = 1 << DATA_AW;
    localparam int DDEPTH = 1 << DESC_AW;

    typedef logic [DATA_AW:0] ptr_t;
    typedef logic [DESC_AW:0] dptr_t;
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} eg_state_t;

    logic [7:0]  mem        [DEPTH];
    ptr_t        desc_start [DDEPTH];
    logic [11:0] desc_len   [DDEPTH];
    logic        desc_err   [DDEPTH];
    logic        desc_drp   [DDEPTH];
    logic [7:0]  desc_seq   [DDEPTH];
    logic [15:0] desc_ts    [DDEPTH];

    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        wr_base_q, wr_base_d;
    logic [12:0] len_cnt_q, len_cnt_d;
    logic        in_pkt_q, in_pkt_d;
    logic        pkt_drop_q, pkt_drop_d;
    logic        drop_flag_q, drop_flag_d;
    logic [7:0]  seq_q, seq_d;
    logic [15:0] ts_q;
    logic [15:0] pkt_ts_q, pkt_ts_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    dptr_t       dwr_q, dwr_d;

    eg_state_t   state_q;
    ptr_t        rd_ptr_q;
    dptr_t       drd_q;
    logic        req_q;
    logic [11:0] xfer_len_q;
    logic [25:0] usdf_q;
    logic [11:0] remaining_q;

    logic                 data_full;
    logic                 desc_full;
    logic                 over_len;
    logic                 drop_now;
    logic                 byte_ok;
    logic                 commit;
    logic [15:0]          cur_ts;
    logic [11:0]          commit_len;
    logic [DESC_AW-1:0]   head;
    logic                 pending;

    // Occupancy uses wr_ptr, so uncommitted bytes of the packet in flight count against space.
    assign data_full  = (ptr_t'(wr_ptr_q - rd_ptr_q)) == ptr_t'(DEPTH);
    assign desc_full  = (dptr_t'(dwr_q - drd_q)) == dptr_t'(DDEPTH);
    assign over_len   = len_cnt_q >= 13'(MAX_LEN);
    assign drop_now   = pkt_drop_q | data_full | over_len | (bus.in_eop & desc_full);
    assign byte_ok    = bus.in_valid & ~drop_now;
    assign commit     = bus.in_valid & bus.in_eop & ~drop_now;
    assign cur_ts     = in_pkt_q ? pkt_ts_q : ts_q;
    assign commit_len = 12'(len_cnt_q + 13'd1);
    assign head       = drd_q[DESC_AW-1:0];
    assign pending    = dwr_q != drd_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_base_d   = wr_base_q;
        len_cnt_d   = len_cnt_q;
        in_pkt_d    = in_pkt_q;
        pkt_drop_d  = pkt_drop_q;
        drop_flag_d = drop_flag_q;
        seq_d       = seq_q;
        pkt_ts_d    = pkt_ts_q;
        drop_cnt_d  = drop_cnt_q;
        dwr_d       = dwr_q;
        if (bus.in_valid) begin
            if (bus.in_eop) begin
                in_pkt_d   = 1'b0;
                pkt_drop_d = 1'b0;
                len_cnt_d  = '0;
                if (drop_now) begin
                    wr_ptr_d    = wr_base_q;
                    drop_flag_d = 1'b1;
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end else begin
                    wr_ptr_d    = wr_ptr_q + ptr_t'(1);
                    wr_base_d   = wr_ptr_q + ptr_t'(1);
                    seq_d       = seq_q + 8'd1;
                    drop_flag_d = 1'b0;
                    dwr_d       = dwr_q + dptr_t'(1);
                end
            end else begin
                in_pkt_d   = 1'b1;
                pkt_drop_d = drop_now;
                if (!in_pkt_q) begin
                    pkt_ts_d = ts_q;
                end
                if (!drop_now) begin
                    wr_ptr_d  = wr_ptr_q + ptr_t'(1);
                    len_cnt_d = len_cnt_q + 13'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            wr_base_q   <= '0;
            len_cnt_q   <= '0;
            in_pkt_q    <= 1'b0;
            pkt_drop_q  <= 1'b0;
            drop_flag_q <= 1'b0;
            seq_q       <= '0;
            ts_q        <= '0;
            pkt_ts_q    <= '0;
            drop_cnt_q  <= '0;
            dwr_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_base_q   <= wr_base_d;
            len_cnt_q   <= len_cnt_d;
            in_pkt_q    <= in_pkt_d;
            pkt_drop_q  <= pkt_drop_d;
            drop_flag_q <= drop_flag_d;
            seq_q       <= seq_d;
            ts_q        <= ts_q + 16'd1;
            pkt_ts_q    <= pkt_ts_d;
            drop_cnt_q  <= drop_cnt_d;
            dwr_q       <= dwr_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (byte_ok) begin
            mem[wr_ptr_q[DATA_AW-1:0]] <= bus.in_data;
        end
        if (commit) begin
            desc_start[dwr_q[DESC_AW-1:0]] <= wr_base_q;
            desc_len[dwr_q[DESC_AW-1:0]]   <= commit_len;
            desc_err[dwr_q[DESC_AW-1:0]]   <= bus.in_err;
            desc_drp[dwr_q[DESC_AW-1:0]]   <= drop_flag_q;
            desc_seq[dwr_q[DESC_AW-1:0]]   <= seq_q;
            desc_ts[dwr_q[DESC_AW-1:0]]    <= cur_ts;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            drd_q       <= '0;
            req_q       <= 1'b0;
            xfer_len_q  <= '0;
            usdf_q      <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending) begin
                        xfer_len_q <= desc_len[head];
                        usdf_q     <= {desc_err[head], desc_drp[head], desc_seq[head], desc_ts[head]};
                        req_q      <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (bus.ack) begin
                        rd_ptr_q    <= rd_ptr_q + ptr_t'(1);
                        remaining_q <= xfer_len_q - 12'd1;
                        req_q       <= 1'b0;
                        state_q     <= XFER;
                    end
                end
                XFER: begin
                    // An ack held past the packet end is not allowed to run into the next packet.
                    if (bus.ack && remaining_q != 12'd0) begin
                        rd_ptr_q    <= rd_ptr_q + ptr_t'(1);
                        remaining_q <= remaining_q - 12'd1;
                    end else begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    rd_ptr_q <= desc_start[head] + ptr_t'(desc_len[head]);
                    drd_q    <= drd_q + dptr_t'(1);
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req          = req_q;
    assign bus.xfer_len     = xfer_len_q;
    assign bus.usdf         = usdf_q;
    assign bus.payload_data = mem[rd_ptr_q[DATA_AW-1:0]];
    assign bus.pkt_pending  = pending;
    assign bus.drop_cnt     = drop_cnt_q;
endmodule

// File: doc/usb_pkt_buffer.md
Name: usb_pkt_buffer

Overview:
- Upstream feeder for the HSPI transmit master. Accepts the byte stream of captured USB packets from the sniffer decoder and buffers whole packets.
- Holds each packet in a data FIFO, with a per-packet descriptor (length, flags, sequence, timestamp) in a descriptor FIFO.
- Presents one packet at a time on the master's req/xfer_len/usdf/ack/payload_data interface. Only complete, committed packets are ever offered.

Parameters:
- DATA_AW, 11: data FIFO address width; depth is 2^DATA_AW bytes.
- DESC_AW, 4: descriptor FIFO address width; depth is 2^DESC_AW packets.
- MAX_LEN, 1024: largest accepted packet in bytes; must be ≤ 2^DATA_AW and ≤ 4095.

Ports:
- clk  in  1  single clock (the HSPI clk); all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data carries a captured byte this cycle
- in_data  in  8  captured byte
- in_eop  in  1  qualified by in_valid; this byte is the last byte of the packet
- in_err  in  1  qualified by in_valid&in_eop; decoder flagged the packet bad (PID/CRC/bitstuff)
- req  out  1  transfer request to HSPI master
- xfer_len  out  12  payload length of the offered packet
- usdf  out  26  user-defined header field of the offered packet
- ack  in  1  master is consuming payload; one byte per cycle while high
- payload_data  out  8  current payload byte (first-word-fall-through)
- pkt_pending  out  1  descriptor FIFO non-empty
- drop_cnt  out  16  saturating count of dropped packets

Behaviour:
- Reset values:
  - req=0, xfer_len=0, usdf=0, drop_cnt=0, pkt_pending=0.
  - All pointers, sequence number, timestamp and flags are 0.
  - Egress FSM = IDLE; ingress is in the not-in-packet state.
  - Reset mid-transfer discards all buffered data.
- Timestamp: free-running 16-bit counter, wraps. It is sampled on the first in_valid byte of each packet.
- Ingress:
  - Bytes are written at wr_ptr. The committed pointer wr_base marks the last packet boundary; len_cnt counts bytes of the current packet.
  - Data FIFO is full when (wr_ptr - rd_ptr) == 2^DATA_AW. All pointer arithmetic is modulo 2^DATA_AW, one extra bit for full/empty.
  - The packet enters the drop condition if any of these occurs: a byte arrives while the data FIFO is full; len_cnt would exceed MAX_LEN; at eop the descriptor FIFO is full. Once set, the condition persists until eop.
  - At eop without drop: push descriptor {start=wr_base, len=len_cnt+1, err=in_err, dropped=drop_flag, seq, timestamp}; wr_base <= wr_ptr+1; seq++; drop_flag <= 0.
  - At eop with drop: wr_ptr <= wr_base (rewind); drop_cnt++ (saturate at FFFF); drop_flag <= 1.
  - in_valid without a byte following eop is never a zero-length packet. A zero-length packet cannot exist because eop rides on a byte.
- usdf = {err, dropped, seq[7:0], timestamp[15:0]}. dropped=1 means at least one packet was lost before this one.
- Egress FSM (IDLE, REQ, XFER, DONE):
  - IDLE: if pkt_pending, register xfer_len=head.len and usdf=head fields; req<=1; go to REQ. xfer_len and usdf stay stable until DONE.
  - REQ: wait indefinitely for ack. On the first cycle with ack=1, byte 0 is consumed that edge: rd_ptr++, remaining<=len-1, req<=0, go to XFER.
  - XFER: each cycle with ack=1, rd_ptr++ and remaining--. When ack=0, go to DONE.
  - DONE: set rd_ptr <=head.start+head.len, which also discards bytes left after an early ack drop. Pop the descriptor and return to IDLE.
  - Minimum gap between packets is 2 cycles.
- payload_data is always the data FIFO read at rd_ptr, combinational or FWFT. The byte for the current ack edge must be valid before that edge.
- ack while in IDLE or DONE is ignored; no pointer moves.
- Simultaneous ingress write and egress read in the same cycle are both honoured. Full is computed from the committed rd_ptr.
- Capacity: the descriptor FIFO is full when it holds 2^DESC_AW entries.

Test Plan:
- Single 3-byte packet AA,BB,CC with eop on CC and in_err=0:
  - req rises 1 cycle after commit; xfer_len=3; usdf={0,0,8'h00,ts}.
  - Model asserts ack for 3 cycles → samples AA,BB,CC; req=0 after the first ack cycle; pkt_pending=0 after DONE.
- Back-to-back: four 64-byte packets, then master idle for 1000 cycles, then accepts all four.
  - Four transfers with seq 0..3 and data intact; no drops.
- Over-length packet of MAX_LEN+1=1025 bytes, followed by a 2-byte packet:
  - drop_cnt=1; only the 2-byte packet is delivered, with usdf dropped=1 and seq=0.
- Data FIFO full: with DATA_AW=4, write a 10-byte and then an 8-byte packet with no egress.
  - The second packet is dropped and wr_ptr rewinds to 10. The first packet still delivers correctly.
- Early ack drop: a 5-byte packet with ack high for only 2 cycles.
  - Bytes 0–1 are delivered. The next packet's first byte is correct (rd_ptr skipped to start+5).
- Reset asserted during XFER, then a new 1-byte packet 5A:
  - Immediately: req=0, drop_cnt=0, pkt_pending=0.
  - After reset: xfer_len=1, seq=0, payload 5A.
